// File: rtl/ipsxe_floating_point_fma_axis_ctrl_v1_0_if.sv
// Stream and core-side signal bundle for the FMA AXI-Stream controller.
// master: the controller's view. slave: the environment (source, core, sink).
interface ipsxe_floating_point_fma_axis_ctrl_v1_0_if #(
  parameter int WIDTH = 32
);
  // operand stream in
  logic               i_s_abc_tvalid;
  logic               o_s_abc_tready;
  logic [3*WIDTH:0]   i_s_abc_tdata;
  // core operand side
  logic [WIDTH-1:0]   o_fma_a;
  logic [WIDTH-1:0]   o_fma_b;
  logic [WIDTH-1:0]   o_fma_c;
  logic               o_fma_op;
  logic               o_fma_abc_valid;
  // core result side
  logic [WIDTH-1:0]   i_fma_result;
  logic               i_fma_result_valid;
  logic               i_fma_invalid_op;
  logic               i_fma_underflow;
  logic               i_fma_overflow;
  // result stream out
  logic               o_m_res_tvalid;
  logic               i_m_res_tready;
  logic [WIDTH+2:0]   o_m_res_tdata;

  modport master (
    input  i_s_abc_tvalid, i_s_abc_tdata,
    output o_s_abc_tready,
    output o_fma_a, o_fma_b, o_fma_c, o_fma_op, o_fma_abc_valid,
    input  i_fma_result, i_fma_result_valid,
    input  i_fma_invalid_op, i_fma_underflow, i_fma_overflow,
    output o_m_res_tvalid, o_m_res_tdata,
    input  i_m_res_tready
  );

  modport slave (
    output i_s_abc_tvalid, i_s_abc_tdata,
    input  o_s_abc_tready,
    input  o_fma_a, o_fma_b, o_fma_c, o_fma_op, o_fma_abc_valid,
    output i_fma_result, i_fma_result_valid,
    output i_fma_invalid_op, i_fma_underflow, i_fma_overflow,
    input  o_m_res_tvalid, o_m_res_tdata,
    output i_m_res_tready
  );
endinterface

// File: rtl/ipsxe_floating_point_fma_axis_ctrl_v1_0.sv
// Stream front end for the fixed-latency FMA core. Operand triples are only
// accepted while a FIFO slot is reserved for their result (in_flight + occ),
// so the un-stallable core can never overflow the result FIFO.
module ipsxe_floating_point_fma_axis_ctrl_v1_0 #(
  parameter int EXP_WIDTH  = 8,
  parameter int MAN_WIDTH  = 23,
  parameter int LATENCY    = 14,
  parameter int FIFO_DEPTH = 32
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_aclken,
  ipsxe_floating_point_fma_axis_ctrl_v1_0_if.master bus,
  output logic o_proto_err
);
  localparam int WIDTH = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int DW    = WIDTH + 3;
  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int UW    = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [UW-1:0] DEPTH_U = UW'(FIFO_DEPTH);

  // Parameter sanity: pointers wrap by natural overflow, so depth must be 2^n.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end

  logic [CW-1:0]    in_flight_q, in_flight_d;
  logic [CW-1:0]    occ_q, occ_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             room_q, room_d;
  logic             abc_valid_q, abc_valid_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic             op_q, op_d;
  logic             err_q, err_d;
  logic [UW-1:0]    used_d;
  logic             accept, cap_req, bad, cap, pop;
  logic [DW-1:0]    mem_q [FIFO_DEPTH];

  // Next-state: accept/capture/pop all apply in the same cycle; clken low freezes everything.
  always_comb begin
    accept      = bus.i_s_abc_tvalid & room_q & i_aclken;
    cap_req     = bus.i_fma_result_valid & i_aclken;
    // a result nobody asked for, or one with no slot, is dropped and flagged
    bad         = cap_req & ((in_flight_q == '0) | (occ_q == DEPTH_C));
    cap         = cap_req & ~bad;
    pop         = (occ_q != '0) & bus.i_m_res_tready & i_aclken;
    in_flight_d = in_flight_q + CW'(accept) - CW'(cap);
    occ_d       = occ_q + CW'(cap) - CW'(pop);
    wr_ptr_d    = wr_ptr_q + PW'(cap);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    used_d      = {1'b0, in_flight_d} + {1'b0, occ_d};
    room_d      = i_aclken ? (used_d < DEPTH_U) : room_q;
    // strobe is held across disabled cycles so the clken-sharing core still sees it
    abc_valid_d = i_aclken ? accept : abc_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    op_d        = op_q;
    if (accept) begin
      a_d  = bus.i_s_abc_tdata[WIDTH-1:0];
      b_d  = bus.i_s_abc_tdata[2*WIDTH-1:WIDTH];
      c_d  = bus.i_s_abc_tdata[3*WIDTH-1:2*WIDTH];
      op_d = bus.i_s_abc_tdata[3*WIDTH];
    end
    err_d       = err_q | bad;
  end

  // Control and operand registers; room starts at 0 so tready rises one edge after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      in_flight_q <= '0;
      occ_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      room_q      <= 1'b0;
      abc_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      in_flight_q <= in_flight_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      room_q      <= room_d;
      abc_valid_q <= abc_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      op_q        <= op_d;
      err_q       <= err_d;
    end
  end

  // Result storage (distributed RAM, no reset); read side is asynchronous.
  always_ff @(posedge i_clk) begin
    if (cap)
      mem_q[wr_ptr_q] <= {bus.i_fma_overflow, bus.i_fma_underflow,
                          bus.i_fma_invalid_op, bus.i_fma_result};
  end

  assign bus.o_s_abc_tready  = room_q & i_aclken;
  assign bus.o_fma_a         = a_q;
  assign bus.o_fma_b         = b_q;
  assign bus.o_fma_c         = c_q;
  assign bus.o_fma_op        = op_q;
  assign bus.o_fma_abc_valid = abc_valid_q;
  assign bus.o_m_res_tvalid  = (occ_q != '0);
  assign bus.o_m_res_tdata   = mem_q[rd_ptr_q];
  assign o_proto_err         = err_q;

endmodule

// File: tb/tb_ipsxe_floating_point_fma_axis_ctrl_v1_0.sv
// Directed bench: table of single-op vectors plus hand-written stream,
// backpressure, spurious-result and clock-enable sequences. A behavioural
// fixed-latency core model feeds the DUT; a scoreboard checks every pop.
module tb_ipsxe_floating_point_fma_axis_ctrl_v1_0;
  localparam int LAT   = 14;
  localparam int DEPTH = 32;
  localparam int W     = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic aclken = 1'b1;
  logic proto_err;
  logic inj = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ipsxe_floating_point_fma_axis_ctrl_v1_0_if #(.WIDTH(W)) bus ();

  ipsxe_floating_point_fma_axis_ctrl_v1_0 #(
    .EXP_WIDTH(8), .MAN_WIDTH(23), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_aclken(aclken), .bus(bus), .o_proto_err(proto_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural core: a few real IEEE cases, otherwise a cheap tag function.
  function automatic logic [W+2:0] core_fn(input logic [31:0] a, b, c, input logic op);
    if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F800000 && !op)
      return {3'b000, 32'h40400000};
    if (a == 32'h7F800000 && b == 32'h0) return {3'b001, 32'h7FC00000};
    if (a == 32'h7F000000 && b == 32'h7F000000) return {3'b100, 32'h7F800000};
    if (a == 32'h00800000 && b == 32'h00800000) return {3'b010, 32'h00000000};
    return {3'b000, a ^ b ^ c ^ {31'b0, op}};
  endfunction

  // Core pipeline: samples the strobe on an enabled edge, result valid LAT-1 edges later.
  logic         pv [LAT];
  logic [W+2:0] pd [LAT];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pd[i] <= '0; end
    end else if (aclken) begin
      pv[0] <= bus.o_fma_abc_valid;
      pd[0] <= core_fn(bus.o_fma_a, bus.o_fma_b, bus.o_fma_c, bus.o_fma_op);
      for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pd[i] <= pd[i-1]; end
    end
  end
  assign bus.i_fma_result_valid = pv[LAT-1] | inj;
  assign bus.i_fma_result       = inj ? 32'hDEADBEEF : pd[LAT-1][W-1:0];
  assign bus.i_fma_invalid_op   = inj ? 1'b0 : pd[LAT-1][W];
  assign bus.i_fma_underflow    = inj ? 1'b0 : pd[LAT-1][W+1];
  assign bus.i_fma_overflow     = inj ? 1'b0 : pd[LAT-1][W+2];

  // Scoreboard: observed at the falling edge, i.e. what the next rising edge transfers.
  logic [W+2:0] sb_q[$];
  int cyc = 0, pops = 0, first_pop = 0, last_pop = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && aclken) begin
      if (bus.i_s_abc_tvalid && bus.o_s_abc_tready)
        sb_q.push_back(core_fn(bus.i_s_abc_tdata[31:0], bus.i_s_abc_tdata[63:32],
                               bus.i_s_abc_tdata[95:64], bus.i_s_abc_tdata[96]));
      if (bus.o_m_res_tvalid && bus.i_m_res_tready) begin
        if (sb_q.size() == 0) chk("pop_without_accept", 64'd1, 64'd0);
        else chk("sb_tdata", 64'(bus.o_m_res_tdata), 64'(sb_q.pop_front()));
        if (pops == 0) first_pop = cyc;
        last_pop = cyc;
        pops++;
      end
    end
  end

  typedef struct {
    logic [31:0] a, b, c;
    logic        op;
    logic [31:0] res;
    logic [2:0]  flg;
  } vec_t;
  vec_t tbl[5];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [31:0] a, b, c, input logic op);
    bus.i_s_abc_tdata = {op, c, b, a};
  endtask

  task automatic do_reset();
    aclken = 1'b1;
    rst_n = 1'b0;
    bus.i_s_abc_tvalid = 1'b0;
    bus.i_s_abc_tdata = '0;
    bus.i_m_res_tready = 1'b0;
    inj = 1'b0;
    sb_q.delete();
    repeat (3) step();
    chk("rst_tready", 64'(bus.o_s_abc_tready), 64'd0);
    chk("rst_m_tvalid", 64'(bus.o_m_res_tvalid), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    chk("rst_abc_valid", 64'(bus.o_fma_abc_valid), 64'd0);
    chk("rst_fma_a_op", 64'({bus.o_fma_op, bus.o_fma_a}), 64'd0);
    rst_n = 1'b1;
    chk("rst_rel_tready_before_edge", 64'(bus.o_s_abc_tready), 64'd0);
    step();
    chk("rst_rel_tready_after_edge", 64'(bus.o_s_abc_tready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n, acc, drops, g;
    logic tr;
    tbl[0] = '{32'h3F800000, 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 3'b000};
    tbl[1] = '{32'h7F800000, 32'h00000000, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001};
    tbl[2] = '{32'h7F000000, 32'h7F000000, 32'h00000000, 1'b0, 32'h7F800000, 3'b100};
    tbl[3] = '{32'h00800000, 32'h00800000, 32'h00000000, 1'b1, 32'h00000000, 3'b010};
    tbl[4] = '{32'h00000001, 32'h00000010, 32'h00000100, 1'b1, 32'h00000110, 3'b000};

    do_reset();

    // Single ops: strobe timing, operand routing, end-to-end latency, payload.
    for (int v = 0; v < 5; v++) begin
      drive(tbl[v].a, tbl[v].b, tbl[v].c, tbl[v].op);
      bus.i_s_abc_tvalid = 1'b1;
      chk("tbl_tready", 64'(bus.o_s_abc_tready), 64'd1);
      step();                              // accept edge
      bus.i_s_abc_tvalid = 1'b0;
      chk("tbl_abc_valid_hi", 64'(bus.o_fma_abc_valid), 64'd1);
      chk("tbl_fma_a", 64'(bus.o_fma_a), 64'(tbl[v].a));
      chk("tbl_fma_c", 64'(bus.o_fma_c), 64'(tbl[v].c));
      chk("tbl_fma_op", 64'(bus.o_fma_op), 64'(tbl[v].op));
      step();
      n = 1;
      chk("tbl_abc_valid_lo", 64'(bus.o_fma_abc_valid), 64'd0);
      while (!bus.o_m_res_tvalid && n < 40) begin step(); n++; end
      // tvalid seen LAT+1 edges after the accept edge = LAT+2 cycles end to end
      chk("tbl_latency_edges", 64'(n), 64'(LAT + 1));
      chk("tbl_tdata", 64'(bus.o_m_res_tdata), 64'({tbl[v].flg, tbl[v].res}));
      chk("tbl_flags", 64'(bus.o_m_res_tdata[W+2:W]), 64'(tbl[v].flg));
      bus.i_m_res_tready = 1'b1;
      step();
      bus.i_m_res_tready = 1'b0;
      chk("tbl_empty_after_pop", 64'(bus.o_m_res_tvalid), 64'd0);
    end

    // 100 back-to-back ops, sink always ready.
    pops = 0; acc = 0; drops = 0;
    bus.i_m_res_tready = 1'b1;
    drive(32'h1000, 32'h0, 32'h0, 1'b0);
    bus.i_s_abc_tvalid = 1'b1;
    g = 0;
    while (acc < 100 && g < 400) begin
      @(negedge clk); tr = bus.o_s_abc_tready;
      if (!tr) drops++;
      step(); g++;
      if (tr) begin
        acc++;
        drive(32'h1000 + acc, acc << 8, acc << 16, acc[0]);
        if (acc == 100) bus.i_s_abc_tvalid = 1'b0;
      end
    end
    g = 0;
    while (pops < 100 && g < 200) begin step(); g++; end
    chk("b2b_tready_drops", 64'(drops), 64'd0);
    chk("b2b_accepts", 64'(acc), 64'd100);
    chk("b2b_results", 64'(pops), 64'd100);
    chk("b2b_one_per_cycle", 64'(last_pop - first_pop + 1), 64'd100);

    // Backpressure: sink stalled, source keeps pushing.
    bus.i_m_res_tready = 1'b0;
    acc = 0;
    drive(32'h5000, 32'h1, 32'h2, 1'b0);
    bus.i_s_abc_tvalid = 1'b1;
    repeat (60) begin
      @(negedge clk); tr = bus.o_s_abc_tready;
      step();
      if (tr) begin acc++; drive(32'h5000 + acc, 32'h1, 32'h2, 1'b0); end
    end
    bus.i_s_abc_tvalid = 1'b0;
    chk("bp_accepts", 64'(acc), 64'(DEPTH));
    chk("bp_tready_low", 64'(bus.o_s_abc_tready), 64'd0);
    chk("bp_m_tvalid", 64'(bus.o_m_res_tvalid), 64'd1);
    chk("bp_no_err", 64'(proto_err), 64'd0);
    pops = 0;
    bus.i_m_res_tready = 1'b1;
    chk("bp_tready_before_pop", 64'(bus.o_s_abc_tready), 64'd0);
    step();                                // first pop edge
    chk("bp_tready_after_pop", 64'(bus.o_s_abc_tready), 64'd1);
    g = 0;
    while (bus.o_m_res_tvalid && g < 100) begin step(); g++; end
    chk("bp_drained", 64'(pops), 64'(DEPTH));
    bus.i_m_res_tready = 1'b0;

    // Spurious core result with nothing in flight.
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("spur_err_set", 64'(proto_err), 64'd1);
    chk("spur_occ_unchanged", 64'(bus.o_m_res_tvalid), 64'd0);
    repeat (3) step();
    chk("spur_err_sticky", 64'(proto_err), 64'd1);
    do_reset();
    chk("spur_err_cleared", 64'(proto_err), 64'd0);

    // Clock enable low mid-stream with a result waiting and room available.
    pops = 0;
    drive(32'h11, 32'h22, 32'h44, 1'b0);
    bus.i_s_abc_tvalid = 1'b1;
    step();
    bus.i_s_abc_tvalid = 1'b0;
    g = 0;
    while (!bus.o_m_res_tvalid && g < 40) begin step(); g++; end
    aclken = 1'b0;
    drive(32'h100, 32'h0, 32'h0, 1'b1);
    bus.i_s_abc_tvalid = 1'b1;
    bus.i_m_res_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("ce_tready_low", 64'(bus.o_s_abc_tready), 64'd0);
      chk("ce_m_tvalid_held", 64'(bus.o_m_res_tvalid), 64'd1);
      chk("ce_tdata_held", 64'(bus.o_m_res_tdata), 64'({3'b000, 32'h00000077}));
      chk("ce_abc_valid_low", 64'(bus.o_fma_abc_valid), 64'd0);
    end
    chk("ce_no_pop", 64'(pops), 64'd0);
    aclken = 1'b1;
    step();                                // pops A, accepts B
    bus.i_s_abc_tvalid = 1'b0;
    chk("ce_resume_abc_valid", 64'(bus.o_fma_abc_valid), 64'd1);
    g = 0;
    while (sb_q.size() != 0 && g < 60) begin step(); g++; end
    step();
    chk("ce_results", 64'(pops), 64'd2);
    chk("ce_sb_empty", 64'(sb_q.size()), 64'd0);
    chk("ce_m_tvalid_end", 64'(bus.o_m_res_tvalid), 64'd0);
    chk("ce_no_err", 64'(proto_err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
